sn74ls193_sync: RTL and testbench
=================================

Name: sn74ls193_sync

Overview:
- Synchronous-clocked emulation of the SN74LS193 4-bit up/down binary counter. It is the down-capable counterpart to the team's up-only ripple counter.
- The emulated count pins UP and DOWN are sampled by a single system clock; their rising edges step the count up or down.
- The block provides parallel load, clear, and carry/borrow outputs so several instances can cascade the way the real IC does.
- Pin names follow the TI datasheet.

Parameters:
- WIDTH, 4, counter width. The 193 is fixed at 4; other values are only for cascading tests.
- SYNC_STAGES, 2, synchronizer flops on UP, DOWN and LOAD_N. 0 bypasses the synchronizer (inputs are assumed already synchronous to CLK).

Ports:
- CLK  input  1  system sample clock; all state updates on its rising edge
- CLR  input  1  clear; synchronous, active-high reset
- UP  input  1  count-up clock pin; a rising edge counts up while DOWN is high
- DOWN  input  1  count-down clock pin; a rising edge counts down while UP is high
- LOAD_N  input  1  parallel load, active low, level-sensitive
- D, C, B, A  input  1 each  parallel data; A is the LSB
- QD, QC, QB, QA  output  1 each  counter state; QA is the LSB; registered
- CO_N  output  1  carry out, active low
- BO_N  output  1  borrow out, active low

Behaviour:
- One clock (CLK); CLR is synchronous and active-high. There is no other reset.
- Reset (CLR=1 at a CLK rising edge):
  - {QD,QC,QB,QA}=0000.
  - All synchronizer and edge-history flops for UP, DOWN and LOAD_N are set to 1, so a pin held high through reset produces no edge.
  - After reset, CO_N=1 and BO_N=1.
- Input path: UP, DOWN and LOAD_N each pass through SYNC_STAGES flops, giving up_s, down_s and load_s.
- Edge detection:
  - up_prev and down_prev hold the previous-cycle up_s and down_s.
  - up_rise = up_s & ~up_prev; down_rise = down_s & ~down_prev.
- Priority per CLK edge, highest first:
  1. CLR: clear as above.
  2. load_s==0: Q <= {D,C,B,A}, sampled directly (not synchronized). Any pending edge is discarded, but up_prev and down_prev still update.
  3. up_rise & down_s & ~down_rise: Q <= Q+1 mod 16. 1111 wraps to 0000.
  4. down_rise & up_s & ~up_rise: Q <= Q-1 mod 16. 0000 wraps to 1111.
  5. Otherwise Q holds. This covers simultaneous rises and a rise while the other pin is low (illegal on the real IC; ignored here).
- Latency: pin edge to Q change is SYNC_STAGES+1 CLK cycles. With SYNC_STAGES=0 it is 1 cycle.
- CO_N = ~(Q==1111 & ~up_s). This is combinational from registered Q and up_s. It pulses low during the UP-low phase at terminal count, matching the datasheet.
- BO_N = ~(Q==0000 & ~down_s). Same construction, using down_s.
- Cascading: the next stage's UP connects to CO_N and its DOWN to BO_N. The CO_N rising edge (UP returning high at 1111) coincides with this stage's wrap to 0000. That edge is the next stage's count pulse.
- CLR asserted mid-pulse (UP low): clear wins. With up_prev forced to 1 at reset, the UP return-high after CLR deasserts is not treated as an edge, so no count occurs.
- LOAD_N held low: Q continuously follows D..A. Count edges that occur during load are lost.
- No X propagation: every register has a defined value after the first CLR.

Decomposition:
- Package sn74ls193_pkg:
  - localparams CNT_W=4, CNT_MAX=4'b1111, CNT_ZERO=4'b0000.
  - A function for terminal-count decode.
- Sub-module sn_edge_sync: a parameterised SYNC_STAGES synchronizer plus rising-edge detector with a reset value of 1. It is instantiated for UP and DOWN. LOAD_N uses the synchronizer only.
- The counter, priority logic and CO_N/BO_N decode stay in the top module.

Test Plan:
- Reset and counting up: CLR=1 for 2 cycles, UP=DOWN=1 → Q=0000, CO_N=1, BO_N=1. Then 3 UP low/high pulses (each phase 4 cycles) → Q=0011, with each step exactly SYNC_STAGES+1 cycles after the UP rise.
- Up wrap and carry: LOAD_N=0 with DCBA=1110 for 4 cycles, release, then 1 UP pulse → Q=1111. During the next UP-low phase, CO_N=0 for exactly the synchronized low duration. UP rise → Q=0000, CO_N=1.
- Down wrap and borrow: from Q=0001, 1 DOWN pulse → Q=0000. During the next DOWN-low phase, BO_N=0. DOWN rise → Q=1111, BO_N=1.
- Priority: LOAD_N=0 with DCBA=1010 while UP pulses → Q stays 1010 with no counts. Then assert CLR together with LOAD_N=0 → Q=0000. Then UP and DOWN rising in the same cycle from both low → Q unchanged.
- Reset mid-pulse: UP=0 at Q=0101, assert CLR for 1 cycle, then UP returns high → Q=0000 and stays 0000 (no spurious count).
- Cascade: two instances (low CO_N→high UP, BO_N→high DOWN), 17 up pulses → {high,low}=0001_0001. Then 18 down pulses → 1111_1111.

Source files
------------

// File: rtl/sn74ls193_sync_pkg.sv
// Shared constants and the carry/borrow decode for the SN74LS193 emulation.
package sn74ls193_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_ZERO = 4'b0000;

  // Terminal-count pulse: active while the counter sits at its limit and
  // the matching count pin is in its low phase.
  function automatic logic tc_low(input logic at_tc, input logic pin_s);
    return at_tc & ~pin_s;
  endfunction

endpackage

// File: rtl/sn74ls193_sync_edge.sv
// Pin synchronizer plus rising-edge detector; every flop resets to 1 so a
// pin held high through reset never looks like an edge.
module sn_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  generate
    if (STAGES == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
      end

      assign dout = sync_q[STAGES-1];
    end
  endgenerate

  assign prev_d = dout;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign rise = dout & ~prev_q;

endmodule

// File: rtl/sn74ls193_sync.sv
// SN74LS193 up/down counter emulated on a single system clock: UP/DOWN are
// sampled pins whose rising edges step the count; load, clear, carry, borrow.
module sn74ls193_sync
  import sn74ls193_pkg::*;
#(
  parameter int WIDTH       = CNT_W,  // must be >= CNT_W; pins expose the low 4 bits
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic UP,
  input  logic DOWN,
  input  logic LOAD_N,
  input  logic D,
  input  logic C,
  input  logic B,
  input  logic A,
  output logic QD,
  output logic QC,
  output logic QB,
  output logic QA,
  output logic CO_N,
  output logic BO_N
);

  logic up_s;
  logic up_rise;
  logic down_s;
  logic down_rise;
  logic load_s;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  sn_edge_sync #(.STAGES(SYNC_STAGES)) u_up_sync (
    .clk  (CLK),
    .rst  (CLR),
    .din  (UP),
    .dout (up_s),
    .rise (up_rise)
  );

  sn_edge_sync #(.STAGES(SYNC_STAGES)) u_down_sync (
    .clk  (CLK),
    .rst  (CLR),
    .din  (DOWN),
    .dout (down_s),
    .rise (down_rise)
  );

  // LOAD_N is level-sensitive, so it only needs the synchronizer chain.
  generate
    if (SYNC_STAGES == 0) begin : g_load_bypass
      assign load_s = LOAD_N;
    end else begin : g_load_sync
      logic [SYNC_STAGES-1:0] load_sync_q;
      logic [SYNC_STAGES-1:0] load_sync_d;

      always_comb begin
        load_sync_d[0] = LOAD_N;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          load_sync_d[i] = load_sync_q[i-1];
        end
      end

      always_ff @(posedge CLK) begin
        if (CLR) load_sync_q <= '1;
        else     load_sync_q <= load_sync_d;
      end

      assign load_s = load_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Data pins bypass the synchronizer; a rise while the other pin is low,
  // or both rising together, leaves the count alone.
  always_comb begin
    q_d = q_q;
    if (!load_s) begin
      q_d            = '0;
      q_d[CNT_W-1:0] = {D, C, B, A};
    end else if (up_rise && down_s && !down_rise) begin
      q_d = q_q + WIDTH'(1);
    end else if (down_rise && up_s && !up_rise) begin
      q_d = q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) q_q <= '0;
    else     q_q <= q_d;
  end

  assign {QD, QC, QB, QA} = q_q[CNT_W-1:0];
  assign CO_N = ~tc_low(&q_q, up_s);
  assign BO_N = ~tc_low(~|q_q, down_s);

endmodule

// File: tb/tb_sn74ls193_sync.sv
// Directed bench for sn74ls193_sync: counting, wrap, carry/borrow, priority,
// reset mid-pulse and a two-stage cascade.
module tb_sn74ls193_sync;

  logic clk;
  logic clr, up, down, load_n;
  logic [3:0] din;
  logic qd, qc, qb, qa, co_n, bo_n;
  logic [3:0] q;

  logic c_clr, c_up, c_down;
  logic lo_qd, lo_qc, lo_qb, lo_qa, lo_co_n, lo_bo_n;
  logic hi_qd, hi_qc, hi_qb, hi_qa, hi_co_n, hi_bo_n;
  logic [7:0] cq;

  int tests_run;
  int tests_failed;

  assign q  = {qd, qc, qb, qa};
  assign cq = {hi_qd, hi_qc, hi_qb, hi_qa, lo_qd, lo_qc, lo_qb, lo_qa};

  sn74ls193_sync u_dut (
    .CLK(clk), .CLR(clr), .UP(up), .DOWN(down), .LOAD_N(load_n),
    .D(din[3]), .C(din[2]), .B(din[1]), .A(din[0]),
    .QD(qd), .QC(qc), .QB(qb), .QA(qa), .CO_N(co_n), .BO_N(bo_n)
  );

  sn74ls193_sync u_lo (
    .CLK(clk), .CLR(c_clr), .UP(c_up), .DOWN(c_down), .LOAD_N(1'b1),
    .D(1'b0), .C(1'b0), .B(1'b0), .A(1'b0),
    .QD(lo_qd), .QC(lo_qc), .QB(lo_qb), .QA(lo_qa), .CO_N(lo_co_n), .BO_N(lo_bo_n)
  );

  sn74ls193_sync u_hi (
    .CLK(clk), .CLR(c_clr), .UP(lo_co_n), .DOWN(lo_bo_n), .LOAD_N(1'b1),
    .D(1'b0), .C(1'b0), .B(1'b0), .A(1'b0),
    .QD(hi_qd), .QC(hi_qc), .QB(hi_qb), .QA(hi_qa), .CO_N(hi_co_n), .BO_N(hi_bo_n)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_up();
    up = 1'b0; tick(4);
    up = 1'b1; tick(4);
  endtask

  task automatic pulse_down();
    down = 1'b0; tick(4);
    down = 1'b1; tick(4);
  endtask

  task automatic pulse_c_up();
    c_up = 1'b0; tick(4);
    c_up = 1'b1; tick(4);
  endtask

  task automatic pulse_c_down();
    c_down = 1'b0; tick(4);
    c_down = 1'b1; tick(4);
  endtask

  task automatic load_value(input logic [3:0] v);
    load_n = 1'b0; din = v; tick(4);
    load_n = 1'b1; tick(4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; up = 1'b1; down = 1'b1; load_n = 1'b1; din = 4'b0000;
    tick(2);
    clr = 1'b0;
    tick(1);
    tests_run++;
    if (q !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_q: got %b expected 0000", q);
    end
    tests_run++;
    if (co_n !== 1'b1) begin
      tests_failed++; $display("FAIL reset_co_n: got %b expected 1", co_n);
    end
    tests_run++;
    if (bo_n !== 1'b1) begin
      tests_failed++; $display("FAIL reset_bo_n: got %b expected 1", bo_n);
    end
  endtask

  task automatic test_count_up();
    for (int s = 1; s <= 3; s++) begin
      up = 1'b0; tick(4);
      up = 1'b1; tick(2);
      tests_run++;
      if (q !== 4'(s - 1)) begin
        tests_failed++; $display("FAIL count_up_early%0d: got %b expected %b", s, q, 4'(s - 1));
      end
      tick(1);
      tests_run++;
      if (q !== 4'(s)) begin
        tests_failed++; $display("FAIL count_up_step%0d: got %b expected %b", s, q, 4'(s));
      end
      tick(1);
    end
  endtask

  task automatic test_up_wrap();
    int low_cnt;
    load_value(4'b1110);
    tests_run++;
    if (q !== 4'b1110) begin
      tests_failed++; $display("FAIL up_wrap_load: got %b expected 1110", q);
    end
    pulse_up();
    tests_run++;
    if (q !== 4'b1111 || co_n !== 1'b1) begin
      tests_failed++; $display("FAIL up_wrap_at_max: got q=%b co_n=%b expected 1111/1", q, co_n);
    end
    low_cnt = 0;
    up = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (co_n === 1'b0) low_cnt++;
      if (i == 3) up = 1'b1;
    end
    tests_run++;
    if (low_cnt != 4) begin
      tests_failed++; $display("FAIL up_wrap_carry_width: got %0d cycles expected 4", low_cnt);
    end
    tests_run++;
    if (q !== 4'b0000 || co_n !== 1'b1) begin
      tests_failed++; $display("FAIL up_wrap_result: got q=%b co_n=%b expected 0000/1", q, co_n);
    end
    tick(2);
  endtask

  task automatic test_down_wrap();
    int low_cnt;
    load_value(4'b0001);
    pulse_down();
    tests_run++;
    if (q !== 4'b0000 || bo_n !== 1'b1) begin
      tests_failed++; $display("FAIL down_wrap_at_zero: got q=%b bo_n=%b expected 0000/1", q, bo_n);
    end
    low_cnt = 0;
    down = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bo_n === 1'b0) low_cnt++;
      if (i == 3) down = 1'b1;
    end
    tests_run++;
    if (low_cnt != 4) begin
      tests_failed++; $display("FAIL down_wrap_borrow_width: got %0d cycles expected 4", low_cnt);
    end
    tests_run++;
    if (q !== 4'b1111 || bo_n !== 1'b1) begin
      tests_failed++; $display("FAIL down_wrap_result: got q=%b bo_n=%b expected 1111/1", q, bo_n);
    end
    tick(2);
  endtask

  task automatic test_priority();
    load_n = 1'b0; din = 4'b1010; tick(4);
    for (int i = 0; i < 3; i++) pulse_up();
    tests_run++;
    if (q !== 4'b1010) begin
      tests_failed++; $display("FAIL prio_load_over_up: got %b expected 1010", q);
    end
    clr = 1'b1; tick(1);
    tests_run++;
    if (q !== 4'b0000) begin
      tests_failed++; $display("FAIL prio_clr_over_load: got %b expected 0000", q);
    end
    clr = 1'b0; load_n = 1'b1; tick(4);
    tests_run++;
    if (q !== 4'b0000) begin
      tests_failed++; $display("FAIL prio_after_clr: got %b expected 0000", q);
    end
    load_value(4'b0110);
    down = 1'b0; tick(4);
    up = 1'b0; tick(4);
    up = 1'b1; tick(6);
    tests_run++;
    if (q !== 4'b0110) begin
      tests_failed++; $display("FAIL prio_up_while_down_low: got %b expected 0110", q);
    end
    up = 1'b0; tick(4);
    up = 1'b1; down = 1'b1; tick(6);
    tests_run++;
    if (q !== 4'b0110) begin
      tests_failed++; $display("FAIL prio_simultaneous_rise: got %b expected 0110", q);
    end
  endtask

  task automatic test_reset_mid_pulse();
    load_value(4'b0101);
    up = 1'b0; tick(4);
    clr = 1'b1; tick(1);
    tests_run++;
    if (q !== 4'b0000) begin
      tests_failed++; $display("FAIL midpulse_clear: got %b expected 0000", q);
    end
    clr = 1'b0; up = 1'b1; tick(8);
    tests_run++;
    if (q !== 4'b0000 || bo_n !== 1'b1) begin
      tests_failed++; $display("FAIL midpulse_no_count: got q=%b bo_n=%b expected 0000/1", q, bo_n);
    end
  endtask

  task automatic test_cascade();
    c_clr = 1'b1; c_up = 1'b1; c_down = 1'b1; tick(2);
    c_clr = 1'b0; tick(2);
    tests_run++;
    if (cq !== 8'h00) begin
      tests_failed++; $display("FAIL cascade_reset: got %h expected 00", cq);
    end
    for (int i = 0; i < 16; i++) pulse_c_up();
    tick(10);
    tests_run++;
    if (cq !== 8'h10) begin
      tests_failed++; $display("FAIL cascade_up16: got %h expected 10", cq);
    end
    pulse_c_up();
    tick(10);
    tests_run++;
    if (cq !== 8'h11) begin
      tests_failed++; $display("FAIL cascade_up17: got %h expected 11", cq);
    end
    for (int i = 0; i < 17; i++) pulse_c_down();
    tick(10);
    tests_run++;
    if (cq !== 8'h00) begin
      tests_failed++; $display("FAIL cascade_down17: got %h expected 00", cq);
    end
    pulse_c_down();
    tick(10);
    tests_run++;
    if (cq !== 8'hFF) begin
      tests_failed++; $display("FAIL cascade_down18: got %h expected ff", cq);
    end
    tests_run++;
    if (hi_co_n !== 1'b1 || hi_bo_n !== 1'b1) begin
      tests_failed++; $display("FAIL cascade_hi_flags: got co_n=%b bo_n=%b expected 1/1", hi_co_n, hi_bo_n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    clr = 1'b1; up = 1'b1; down = 1'b1; load_n = 1'b1; din = 4'b0000;
    c_clr = 1'b1; c_up = 1'b1; c_down = 1'b1;
    test_reset();
    test_count_up();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_reset_mid_pulse();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
